// File: rtl/ram_dp_param.sv
// Simple dual-port RAM with byte-enabled writes, 1- or 2-cycle registered reads,
// selectable read-during-write behaviour and an optional zero-fill after reset.
module ram_dp_param #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned ADDR_W         = 6,
  parameter int unsigned RD_LAT         = 1,
  parameter int unsigned RDW_MODE       = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     write_addr,
  input  logic [DATA_W-1:0]     data,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     read_addr,
  output logic [DATA_W-1:0]     q,
  output logic                  q_valid,
  output logic                  busy
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {ST_CLEAR, ST_READY} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                wr_en_c;
  logic [ADDR_W-1:0]   wr_addr_c;
  logic [DATA_W-1:0]   wr_data_c;
  logic [NB-1:0]       wr_be_c;

  logic                rd_fire_c;
  logic                rdw_hit_c;
  logic [DATA_W-1:0]   rd_word_c;

  // Stage 0 captures the array word on the sampling edge; stages 1..RD_LAT are output registers.
  logic [RD_LAT:0]     vld_q;
  logic [DATA_W-1:0]   dat_q [RD_LAT+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Zero-fill sequencer: one word per cycle, ascending, then park in READY until reset.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    unique case (state_q)
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == {ADDR_W{1'b1}}) begin
          state_d = ST_READY;
        end
      end
      default: ;
    endcase
  end

  assign busy = (state_q == ST_CLEAR);

  // The clear sequence owns the write port while busy; user writes are dropped.
  always_comb begin
    wr_en_c   = we;
    wr_addr_c = write_addr;
    wr_data_c = data;
    wr_be_c   = be;
    if (busy) begin
      wr_en_c   = 1'b1;
      wr_addr_c = clr_addr_q;
      wr_data_c = '0;
      wr_be_c   = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wr_be_c[i]) begin
          mem[wr_addr_c][8*i +: 8] <= wr_data_c[8*i +: 8];
        end
      end
    end
  end

  assign rd_fire_c = re && !busy;
  assign rdw_hit_c = (RDW_MODE != 0) && we && !busy && (write_addr == read_addr);

  // New-data mode forwards the enabled write lanes over the pre-write word.
  always_comb begin
    rd_word_c = mem[read_addr];
    if (rdw_hit_c) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (be[i]) begin
          rd_word_c[8*i +: 8] = data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int unsigned i = 0; i <= RD_LAT; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q <= {vld_q[RD_LAT-1:0], rd_fire_c};
      if (rd_fire_c) begin
        dat_q[0] <= rd_word_c;
      end
      for (int unsigned i = 1; i <= RD_LAT; i++) begin
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
        end
      end
    end
  end

  assign q       = dat_q[RD_LAT];
  assign q_valid = vld_q[RD_LAT];

endmodule

// File: tb/tb_ram_dp_param.sv
// Bench for ram_dp_param: an 8-bit/RD_LAT=1/old-data instance and a
// 32-bit/RD_LAT=2/new-data instance checked against array+queue reference models.
module tb_ram_dp_param;

  localparam int unsigned LAT_A = 1;
  localparam int unsigned LAT_B = 2;
  localparam int unsigned RDW_A = 0;
  localparam int unsigned RDW_B = 1;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        we_a, re_a, qv_a, busy_a;
  logic [0:0]  be_a;
  logic [5:0]  wa_a, ra_a;
  logic [7:0]  d_a, q_a;

  logic        we_b, re_b, qv_b, busy_b;
  logic [3:0]  be_b;
  logic [5:0]  wa_b, ra_b;
  logic [31:0] d_b, q_b;

  int unsigned cyc = 0;
  int          vecs = 0;
  int          errs = 0;

  // Reference model: word arrays plus queues of (due edge, data) read results.
  logic [7:0]  mem_a [64];
  logic [31:0] mem_b [64];
  int unsigned due_a[$], due_b[$];
  logic [7:0]  dat_a[$];
  logic [31:0] dat_b[$];
  logic        ev_a, ev_b;
  logic [7:0]  eq_a;
  logic [31:0] eq_b;

  ram_dp_param #(.DATA_W(8), .ADDR_W(6), .RD_LAT(LAT_A), .RDW_MODE(RDW_A), .CLEAR_ON_RESET(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .we(we_a), .be(be_a), .write_addr(wa_a), .data(d_a),
    .re(re_a), .read_addr(ra_a), .q(q_a), .q_valid(qv_a), .busy(busy_a));

  ram_dp_param #(.DATA_W(32), .ADDR_W(6), .RD_LAT(LAT_B), .RDW_MODE(RDW_B), .CLEAR_ON_RESET(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .we(we_b), .be(be_b), .write_addr(wa_b), .data(d_b),
    .re(re_b), .read_addr(ra_b), .q(q_b), .q_valid(qv_b), .busy(busy_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d got no finish, want finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic set_idle();
    we_a = 1'b0; be_a = 1'b0; wa_a = '0; d_a = '0; re_a = 1'b0; ra_a = '0;
    we_b = 1'b0; be_b = '0;   wa_b = '0; d_b = '0; re_b = 1'b0; ra_b = '0;
  endtask

  task automatic model_reset();
    due_a.delete(); dat_a.delete(); due_b.delete(); dat_b.delete();
    eq_a = '0; eq_b = '0; ev_a = 1'b0; ev_b = 1'b0;
  endtask

  task automatic model_cleared();
    for (int i = 0; i < 64; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
  endtask

  // Drive one cycle on both instances, advance the model, and leave the
  // expected q/q_valid for the edge just taken in ev_*/eq_*.
  task automatic tick(input logic a_we, input logic a_be, input logic [5:0] a_wa, input logic [7:0] a_d,
                      input logic a_re, input logic [5:0] a_ra,
                      input logic b_we, input logic [3:0] b_be, input logic [5:0] b_wa, input logic [31:0] b_d,
                      input logic b_re, input logic [5:0] b_ra);
    logic [7:0]  wa;
    logic [31:0] wb;
    @(negedge clk);
    we_a = a_we; be_a = a_be; wa_a = a_wa; d_a = a_d; re_a = a_re; ra_a = a_ra;
    we_b = b_we; be_b = b_be; wa_b = b_wa; d_b = b_d; re_b = b_re; ra_b = b_ra;
    if (a_re) begin
      wa = mem_a[a_ra];
      if (RDW_A == 1 && a_we && a_be && a_wa == a_ra) wa = a_d;
      due_a.push_back(cyc + 1 + LAT_A);
      dat_a.push_back(wa);
    end
    if (a_we && a_be) mem_a[a_wa] = a_d;
    if (b_re) begin
      wb = mem_b[b_ra];
      if (RDW_B == 1 && b_we && b_wa == b_ra)
        for (int l = 0; l < 4; l++) if (b_be[l]) wb[8*l +: 8] = b_d[8*l +: 8];
      due_b.push_back(cyc + 1 + LAT_B);
      dat_b.push_back(wb);
    end
    if (b_we)
      for (int l = 0; l < 4; l++) if (b_be[l]) mem_b[b_wa][8*l +: 8] = b_d[8*l +: 8];
    @(posedge clk);
    #1;
    ev_a = 1'b0;
    if (due_a.size() > 0 && due_a[0] == cyc) begin
      ev_a = 1'b1; eq_a = dat_a.pop_front(); void'(due_a.pop_front());
    end
    ev_b = 1'b0;
    if (due_b.size() > 0 && due_b[0] == cyc) begin
      ev_b = 1'b1; eq_b = dat_b.pop_front(); void'(due_b.pop_front());
    end
  endtask

  task automatic idle_tick();
    tick(1'b0, 1'b0, 6'd0, 8'd0, 1'b0, 6'd0, 1'b0, 4'd0, 6'd0, 32'd0, 1'b0, 6'd0);
  endtask

  task automatic test_reset();
    set_idle();
    model_reset();
    rst_n = 1'b0;
    #12;
    vecs++; if (q_a !== 8'h00)   begin errs++; $display("FAIL reset_q_a got %h want 00", q_a); end
    vecs++; if (qv_a !== 1'b0)   begin errs++; $display("FAIL reset_qv_a got %b want 0", qv_a); end
    vecs++; if (busy_a !== 1'b1) begin errs++; $display("FAIL reset_busy_a got %b want 1", busy_a); end
    vecs++; if (q_b !== 32'h0)   begin errs++; $display("FAIL reset_q_b got %h want 0", q_b); end
    vecs++; if (qv_b !== 1'b0)   begin errs++; $display("FAIL reset_qv_b got %b want 0", qv_b); end
    vecs++; if (busy_b !== 1'b1) begin errs++; $display("FAIL reset_busy_b got %b want 1", busy_b); end
  endtask

  // Release reset, hammer writes/reads at address 3 while busy, count busy cycles.
  task automatic test_clear();
    int n = 0;
    logic [5:0] addrs [4] = '{6'd0, 6'd31, 6'd63, 6'd3};
    @(negedge clk);
    we_a = 1'b1; be_a = 1'b1; wa_a = 6'd3; d_a = 8'hFF; re_a = 1'b1; ra_a = 6'd3;
    we_b = 1'b1; be_b = 4'hF; wa_b = 6'd3; d_b = 32'hFFFF_FFFF; re_b = 1'b1; ra_b = 6'd3;
    rst_n = 1'b1;
    while (busy_a === 1'b1 && n < 200) begin
      n++;
      vecs++;
      if (qv_a !== 1'b0 || qv_b !== 1'b0 || busy_b !== 1'b1) begin
        errs++; $display("FAIL clear_gate n=%0d got qv_a=%b qv_b=%b busy_b=%b want 0 0 1", n, qv_a, qv_b, busy_b);
      end
      @(negedge clk);
    end
    set_idle();
    vecs++; if (n != 64) begin errs++; $display("FAIL clear_busy_len got %0d want 64", n); end
    vecs++; if (busy_b !== 1'b0) begin errs++; $display("FAIL clear_busy_b_end got %b want 0", busy_b); end
    model_cleared();
    for (int k = 0; k < 7; k++) begin
      if (k < 4) tick(1'b0, 1'b0, 6'd0, 8'd0, 1'b1, addrs[k], 1'b0, 4'd0, 6'd0, 32'd0, 1'b1, addrs[k]);
      else       idle_tick();
      vecs++; if (qv_a !== ev_a || q_a !== eq_a) begin errs++; $display("FAIL clear_read_a cyc=%0d got v=%b q=%h want v=%b q=%h", cyc, qv_a, q_a, ev_a, eq_a); end
      vecs++; if (qv_b !== ev_b || q_b !== eq_b) begin errs++; $display("FAIL clear_read_b cyc=%0d got v=%b q=%h want v=%b q=%h", cyc, qv_b, q_b, ev_b, eq_b); end
    end
  endtask

  task automatic test_byte_enable();
    int seen = 0;
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: tick(1'b0, 1'b0, 6'd0, 8'd0, 1'b0, 6'd0, 1'b1, 4'b1111, 6'd5, 32'hAABBCCDD, 1'b0, 6'd0);
        1: tick(1'b0, 1'b0, 6'd0, 8'd0, 1'b0, 6'd0, 1'b1, 4'b0101, 6'd5, 32'h11223344, 1'b0, 6'd0);
        2: tick(1'b0, 1'b0, 6'd0, 8'd0, 1'b0, 6'd0, 1'b0, 4'd0, 6'd0, 32'd0, 1'b1, 6'd5);
        default: idle_tick();
      endcase
      vecs++; if (qv_b !== ev_b || q_b !== eq_b) begin errs++; $display("FAIL be_model cyc=%0d got v=%b q=%h want v=%b q=%h", cyc, qv_b, q_b, ev_b, eq_b); end
      if (qv_b === 1'b1) begin
        seen++;
        vecs++; if (q_b !== 32'hAA22CC44) begin errs++; $display("FAIL be_word got %h want aa22cc44", q_b); end
      end
    end
    vecs++; if (seen != 1) begin errs++; $display("FAIL be_count got %0d want 1", seen); end
  endtask

  // Three consecutive reads on the RD_LAT=2 instance: results on edges +2..+4, in order.
  task automatic test_back_to_back();
    logic [31:0] want;
    logic        wv;
    for (int k = 1; k <= 3; k++)
      tick(1'b0, 1'b0, 6'd0, 8'd0, 1'b0, 6'd0, 1'b1, 4'hF, 6'(k), 32'(k), 1'b0, 6'd0);
    for (int k = 0; k < 7; k++) begin
      tick(1'b0, 1'b0, 6'd0, 8'd0, 1'b0, 6'd0, 1'b0, 4'd0, 6'd0, 32'd0, (k < 3), 6'(k + 1));
      wv   = (k >= 2 && k <= 4);
      want = 32'(k - 1);
      vecs++; if (qv_b !== ev_b || q_b !== eq_b) begin errs++; $display("FAIL b2b_model cyc=%0d got v=%b q=%h want v=%b q=%h", cyc, qv_b, q_b, ev_b, eq_b); end
      vecs++; if (qv_b !== wv || (wv && q_b !== want)) begin errs++; $display("FAIL b2b_lat step=%0d got v=%b q=%h want v=%b q=%h", k, qv_b, q_b, wv, want); end
    end
  endtask

  task automatic test_rdw();
    logic [7:0]  wa [2] = '{8'h55, 8'h99};
    logic [31:0] wb [2] = '{32'h99, 32'h99};
    int na = 0, nb = 0;
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: tick(1'b1, 1'b1, 6'd7, 8'h55, 1'b0, 6'd0, 1'b1, 4'hF, 6'd7, 32'h55, 1'b0, 6'd0);
        1: tick(1'b1, 1'b1, 6'd7, 8'h99, 1'b1, 6'd7, 1'b1, 4'hF, 6'd7, 32'h99, 1'b1, 6'd7);
        2: tick(1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 6'd7, 1'b0, 4'h0, 6'd0, 32'h00, 1'b1, 6'd7);
        default: idle_tick();
      endcase
      vecs++; if (qv_a !== ev_a || q_a !== eq_a) begin errs++; $display("FAIL rdw_model_a cyc=%0d got v=%b q=%h want v=%b q=%h", cyc, qv_a, q_a, ev_a, eq_a); end
      vecs++; if (qv_b !== ev_b || q_b !== eq_b) begin errs++; $display("FAIL rdw_model_b cyc=%0d got v=%b q=%h want v=%b q=%h", cyc, qv_b, q_b, ev_b, eq_b); end
      if (qv_a === 1'b1 && na < 2) begin
        vecs++; if (q_a !== wa[na]) begin errs++; $display("FAIL rdw_old_a idx=%0d got %h want %h", na, q_a, wa[na]); end
        na++;
      end
      if (qv_b === 1'b1 && nb < 2) begin
        vecs++; if (q_b !== wb[nb]) begin errs++; $display("FAIL rdw_new_b idx=%0d got %h want %h", nb, q_b, wb[nb]); end
        nb++;
      end
    end
    vecs++; if (na != 2 || nb != 2) begin errs++; $display("FAIL rdw_count got a=%0d b=%0d want 2 2", na, nb); end
  endtask

  // Random traffic on a small address window so same-address collisions are frequent.
  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      tick(1'($urandom), 1'($urandom), 6'($urandom_range(0, 7)), 8'($urandom),
           1'($urandom), 6'($urandom_range(0, 7)),
           1'($urandom), 4'($urandom), 6'($urandom_range(0, 7)), 32'($urandom),
           1'($urandom), 6'($urandom_range(0, 7)));
      vecs++; if (qv_a !== ev_a || q_a !== eq_a) begin errs++; $display("FAIL rand_a cyc=%0d got v=%b q=%h want v=%b q=%h", cyc, qv_a, q_a, ev_a, eq_a); end
      vecs++; if (qv_b !== ev_b || q_b !== eq_b) begin errs++; $display("FAIL rand_b cyc=%0d got v=%b q=%h want v=%b q=%h", cyc, qv_b, q_b, ev_b, eq_b); end
    end
    for (int k = 0; k < 4; k++) begin
      idle_tick();
      vecs++; if (qv_a !== ev_a || q_a !== eq_a) begin errs++; $display("FAIL rand_flush_a cyc=%0d got v=%b q=%h want v=%b q=%h", cyc, qv_a, q_a, ev_a, eq_a); end
      vecs++; if (qv_b !== ev_b || q_b !== eq_b) begin errs++; $display("FAIL rand_flush_b cyc=%0d got v=%b q=%h want v=%b q=%h", cyc, qv_b, q_b, ev_b, eq_b); end
    end
  endtask

  // Reset with reads in flight, then reset again at clear cycle 20.
  task automatic test_reset_inflight();
    int n;
    tick(1'b1, 1'b1, 6'd50, 8'h5A, 1'b0, 6'd0, 1'b1, 4'hF, 6'd50, 32'hDEADBEEF, 1'b0, 6'd0);
    tick(1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 6'd50, 1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 6'd50);
    for (int k = 0; k < 3; k++) idle_tick();
    vecs++; if (q_a !== 8'h5A || q_b !== 32'hDEADBEEF) begin errs++; $display("FAIL pre_reset_q got %h %h want 5a deadbeef", q_a, q_b); end
    tick(1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 6'd50, 1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 6'd50);
    @(negedge clk);
    set_idle();
    rst_n = 1'b0;
    model_reset();
    #1;
    vecs++; if (q_a !== 8'h0 || qv_a !== 1'b0 || busy_a !== 1'b1) begin errs++; $display("FAIL inflight_rst_a got q=%h v=%b busy=%b want 00 0 1", q_a, qv_a, busy_a); end
    vecs++; if (q_b !== 32'h0 || qv_b !== 1'b0 || busy_b !== 1'b1) begin errs++; $display("FAIL inflight_rst_b got q=%h v=%b busy=%b want 0 0 1", q_b, qv_b, busy_b); end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (busy_a === 1'b1 && n < 20) begin
      n++;
      vecs++; if (qv_a !== 1'b0 || qv_b !== 1'b0) begin errs++; $display("FAIL inflight_discard n=%0d got %b %b want 0 0", n, qv_a, qv_b); end
      @(negedge clk);
    end
    vecs++; if (n != 20) begin errs++; $display("FAIL midclear_reach got %0d want 20", n); end
    rst_n = 1'b0;
    #1;
    vecs++; if (q_a !== 8'h0 || qv_a !== 1'b0 || busy_a !== 1'b1) begin errs++; $display("FAIL midclear_rst_a got q=%h v=%b busy=%b want 00 0 1", q_a, qv_a, busy_a); end
    vecs++; if (q_b !== 32'h0 || qv_b !== 1'b0 || busy_b !== 1'b1) begin errs++; $display("FAIL midclear_rst_b got q=%h v=%b busy=%b want 0 0 1", q_b, qv_b, busy_b); end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (busy_a === 1'b1 && n < 200) begin
      n++;
      vecs++; if (qv_a !== 1'b0 || qv_b !== 1'b0 || busy_b !== 1'b1) begin errs++; $display("FAIL reclear_gate n=%0d got %b %b busy_b=%b want 0 0 1", n, qv_a, qv_b, busy_b); end
      @(negedge clk);
    end
    vecs++; if (n != 64) begin errs++; $display("FAIL reclear_busy_len got %0d want 64", n); end
    model_cleared();
    for (int k = 0; k < 4; k++) begin
      if (k == 0) tick(1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 6'd50, 1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 6'd50);
      else        idle_tick();
      vecs++; if (qv_a !== ev_a || q_a !== eq_a) begin errs++; $display("FAIL reclear_read_a cyc=%0d got v=%b q=%h want v=%b q=%h", cyc, qv_a, q_a, ev_a, eq_a); end
      vecs++; if (qv_b !== ev_b || q_b !== eq_b) begin errs++; $display("FAIL reclear_read_b cyc=%0d got v=%b q=%h want v=%b q=%h", cyc, qv_b, q_b, ev_b, eq_b); end
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_byte_enable();
    test_back_to_back();
    test_rdw();
    test_random();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/ram_dp_param.md
RAM_DP_PARAM -- requirements
Module: ram_dp_param

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 8, data width in bits; it SHALL be a multiple of 8 and at least 8.
REQ-002 The block SHALL provide parameter ADDR_W, default 6, address width; depth = 2**ADDR_W words.
REQ-003 The block SHALL provide parameter RD_LAT, default 1, read latency in cycles; legal values are 1 and 2.
REQ-004 The block SHALL provide parameter RDW_MODE, default 0, same-address read-during-write result; 0 = old data, 1 = new data.
REQ-005 The block SHALL provide parameter CLEAR_ON_RESET, default 1; 1 = zero-fill the whole array after reset.
REQ-006 The block SHALL provide port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-007 The block SHALL provide port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-008 The block SHALL provide port we, input, 1 bit, write enable, active high.
REQ-009 The block SHALL provide port be, input, DATA_W/8 bits, byte enables for writes; bit i covers data[8i+7:8i].
REQ-010 The block SHALL provide port write_addr, input, ADDR_W bits, the write address.
REQ-011 The block SHALL provide port data, input, DATA_W bits, the write data.
REQ-012 The block SHALL provide port re, input, 1 bit, read enable, active high.
REQ-013 The block SHALL provide port read_addr, input, ADDR_W bits, the read address.
REQ-014 The block SHALL provide port q, output, DATA_W bits, the registered read data.
REQ-015 The block SHALL provide port q_valid, output, 1 bit; it SHALL pulse high for one cycle when q carries the result of a read.
REQ-016 The block SHALL provide port busy, output, 1 bit; high while the zero-fill sequence runs.

Function
REQ-017 Write: on a clk edge with we=1 and busy=0, byte lane i of word write_addr SHALL take data lane i for every i with be[i]=1; lanes with be[i]=0 SHALL keep their value.
REQ-018 Read: re=1 with read_addr=A sampled at edge N, with busy=0, SHALL present the word at A on q with q_valid=1 after edge N+RD_LAT.
REQ-019 q_valid SHALL be 0 on every cycle with no read result due; q SHALL hold its last value between results.
REQ-020 Reads SHALL be fully pipelined: back-to-back re on consecutive cycles SHALL produce consecutive q_valid pulses, in order.
REQ-021 With RD_LAT=2, the second stage SHALL be a pure output register: no stall and no backpressure.
REQ-022 Same cycle, same address, with RDW_MODE=0: the read result SHALL be the word content before the write.
REQ-023 Same cycle, same address, with RDW_MODE=1: the read result SHALL be the post-write word, i.e. data lanes where be=1 and old lanes elsewhere.
REQ-024 When read and write addresses differ in the same cycle, both operations SHALL complete independently.
REQ-025 A write to address A at edge N SHALL be visible to any read of A sampled at edge N+1 or later, regardless of RDW_MODE.
REQ-026 The zero-fill sequencer SHALL be a two-state machine, CLEAR and READY.
REQ-027 CLEAR SHALL write all-zero words with all lanes enabled, one word per cycle, to addresses 0 through 2**ADDR_W-1 in ascending order.
REQ-028 The sequencer SHALL move from CLEAR to READY on the edge that writes the last address.
REQ-029 The sequencer SHALL leave READY only on reset.
REQ-030 busy SHALL be 1 exactly while the sequencer is in CLEAR; with the default ADDR_W=6, busy SHALL be high for 64 cycles after reset release.
REQ-031 While busy=1, we and re SHALL be ignored: no array update, no q_valid, and no queued read.
REQ-032 With CLEAR_ON_RESET=0, the sequencer SHALL enter READY directly, busy SHALL stay 0, and array contents SHALL be undefined until written.

Reset
REQ-033 rst_n=0 SHALL immediately force q=0, q_valid=0, all read pipeline valids to 0, and the clear address counter to 0.
REQ-034 rst_n=0 SHALL force busy=CLEAR_ON_RESET and the sequencer state to CLEAR if CLEAR_ON_RESET=1, else READY.
REQ-035 Reset SHALL NOT directly modify the array; it SHALL be zeroed only by the CLEAR sequence.
REQ-036 Reset asserted mid-CLEAR SHALL restart the zero-fill from address 0 after release.
REQ-037 Reset asserted with reads in flight SHALL discard those reads; no q_valid SHALL appear for them.

Verification
REQ-038 Clear check (defaults): release rst_n -> busy=1 for exactly 64 cycles; afterwards, reads of addresses 0, 31 and 63 return 0x00.
REQ-039 Byte enables (DATA_W=32): write 0xAABBCCDD to address 5 with be=1111, then 0x11223344 with be=0101 -> a read of 5 returns 0xAA22CC44.
REQ-040 Read latency: RD_LAT=2, re at edges 10, 11 and 12 for addresses 1, 2 and 3 holding 0x01/0x02/0x03 -> q_valid high at edges 12-14 with q=0x01, 0x02, 0x03.
REQ-041 Read-during-write: address 7 holds 0x55; same-cycle write 0x99 and read of 7 -> q=0x55 with RDW_MODE=0, q=0x99 with RDW_MODE=1; the next read returns 0x99 in both modes.
REQ-042 Busy gating and reset mid-clear: we=1 writing 0xFF to address 3 during busy -> address 3 still reads 0x00; pull rst_n low at clear cycle 20 -> q=0, q_valid=0, and busy high for a full 64 cycles after release.
